// File: rtl/pattern_tx_pkg.sv
// Shared constants for the serial pattern transmitter.
// Holds the one-hot state encodings and the 01010101 test pattern.
package pattern_tx_pkg;

    // One-hot state encodings.
    localparam logic [2:0] TX_IDLE  = 3'b001;
    localparam logic [2:0] TX_SHIFT = 3'b010;
    localparam logic [2:0] TX_DONE  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = TX_IDLE,
        ST_SHIFT = TX_SHIFT,
        ST_DONE  = TX_DONE
    } tx_state_e;

    // Pattern the downstream Moore detector looks for.
    localparam logic [7:0] PAT_0101 = 8'b01010101;

endpackage

// File: rtl/pattern_tx_piso_shift.sv
// Parallel-load, left-shifting register for pattern_tx.
// Ports: clk, rst (sync, active high), ld (load pdata), sh (shift left),
//        pdata (parallel word), nxt (bit that follows the current MSB).
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] pdata,
    output logic             nxt
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load wins over shift; zeros fill from the LSB side.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = pdata;
        end else if (sh) begin
            q_d = q_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // The MSB is already on the line; the owner wants the one after it.
    assign nxt = q_q[WIDTH-2];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: captures a word and shifts it out MSB-first,
// optionally repeating it back-to-back, then pulses done for one cycle.
// Ports: clk, rst (sync, active high), load/data/rpt (start request),
//        ready (idle), busy (bits on line), dout (registered serial), done.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   REP_W    = 4,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [REP_W-1:0] rpt,
    output logic             ready,
    output logic             busy,
    output logic             dout,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic             dout_q;
    logic             dout_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic [BCW-1:0]   bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;

    logic             sh_ld;
    logic             sh_en;
    logic [WIDTH-1:0] sh_pdata;
    logic             sh_nxt;

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .ld    (sh_ld),
        .sh    (sh_en),
        .pdata (sh_pdata),
        .nxt   (sh_nxt)
    );

    always_comb begin
        state_d   = state_q;
        dout_d    = IDLE_BIT;
        hold_d    = hold_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        sh_ld     = 1'b0;
        sh_en     = 1'b0;
        sh_pdata  = data;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d   = ST_SHIFT;
                    hold_d    = data;
                    rep_cnt_d = rpt;
                    bit_cnt_d = BC_LAST;
                    sh_ld     = 1'b1;
                    // First bit goes out on the same edge as capture.
                    dout_d    = data[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    sh_en     = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    dout_d    = sh_nxt;
                end else if (rep_cnt_q != '0) begin
                    // Next copy starts without an idle bit in between.
                    sh_ld     = 1'b1;
                    sh_pdata  = hold_q;
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    bit_cnt_d = BC_LAST;
                    dout_d    = hold_q[WIDTH-1];
                end else begin
                    state_d   = ST_DONE;
                    dout_d    = IDLE_BIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dout_q    <= IDLE_BIT;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            hold_q    <= hold_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign dout  = dout_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed self-checking bench for pattern_tx.
// Drives #1 after each rising edge and samples at the same point.
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic [3:0] rpt;
    logic       ready;
    logic       busy;
    logic       dout;
    logic       done;

    int errs = 0;
    int nchk = 0;

    pattern_tx #(
        .WIDTH    (8),
        .REP_W    (4),
        .IDLE_BIT (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .rpt   (rpt),
        .ready (ready),
        .busy  (busy),
        .dout  (dout),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".dout"}, dout, 1);
        chk({tag, ".ready"}, ready, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    // Sends d with r extra copies; optionally pokes load while busy.
    // Counts 01010101 windows seen on the line and compares to exp_hits.
    task automatic send(input logic [7:0] d, input logic [3:0] r,
                        input bit poke, input int exp_hits);
        int         n;
        int         hits;
        logic [7:0] win;
        hits = 0;
        win  = 8'h00;
        n    = 8 * (int'(r) + 1);
        load = 1'b1;
        data = d;
        rpt  = r;
        step();
        load = 1'b0;
        data = ~d;
        rpt  = 4'hF;
        for (int i = 0; i < n; i++) begin
            chk("bit", dout, d[7 - (i % 8)]);
            chk("busy", busy, 1);
            chk("ready_busy", ready, 0);
            chk("done_early", done, 0);
            win = {win[6:0], dout};
            if (i >= 7 && win == PAT_0101) hits++;
            load = poke && (i % 5 == 2);
            data = 8'h3C;
            step();
        end
        // Load during DONE must be ignored.
        load = 1'b1;
        data = 8'h00;
        chk("done_pulse", done, 1);
        chk("done.ready", ready, 0);
        chk("done.busy", busy, 0);
        chk("done.dout", dout, 1);
        chk("hits", hits, exp_hits);
        step();
        load = 1'b0;
        chk_idle("after_done");
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b1;
        data = 8'hFF;
        rpt  = 4'h0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("rst_hold");
        end
        rst  = 1'b0;
        load = 1'b0;
        step();
        chk_idle("post_rst");

        send(8'h55, 4'h0, 1'b0, 1);
        send(PAT_0101, 4'h1, 1'b0, 5);
        send(8'hA5, 4'h2, 1'b1, 0);

        // Abort mid-word: 8'hC3 = 1100_0011, bit 4 on the line is 0.
        load = 1'b1;
        data = 8'hC3;
        rpt  = 4'h0;
        step();
        load = 1'b0;
        step();
        step();
        step();
        chk("mid.bit4", dout, 0);
        chk("mid.busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort.nodone", done, 0);
            chk("abort.dout", dout, 1);
        end
        send(8'h0F, 4'h0, 1'b0, 0);

        // Maximum repeat count: 16 copies, 128 bits, then a fresh word.
        send(8'h01, 4'hF, 1'b1, 0);
        send(8'h0F, 4'h0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the single-bit `din` line used by the 01010101 Moore sequence detector.
- Captures a parallel word and shifts it out MSB-first, one bit per clock.
- Optionally repeats the word back-to-back with no gap, so overlapping detection can be exercised.
- Signals completion with a one-cycle `done` pulse.

Parameters:
- WIDTH, 8: bits per word; legal range 2 to 32.
- REP_W, 4: width of the repeat-count input.
- IDLE_BIT, 1'b1: level driven on `dout` when no word is in flight. A 1 keeps the detector parked in its idle state.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- load, input, 1: start request, sampled only while `ready`=1.
- data, input, WIDTH: word to transmit, captured on an accepted `load`.
- rpt, input, REP_W: number of extra repetitions, captured with `data`; 0 means send once.
- ready, output, 1: high in IDLE; a load is accepted when `load` && `ready` at a rising edge.
- busy, output, 1: high while bits are on the line (SHIFT state).
- dout, output, 1: serial data, registered.
- done, output, 1: one-cycle pulse after the last bit.

Behaviour:
- Reset (sampled at a rising edge with rst=1):
  - state=IDLE; dout=IDLE_BIT; done=0; busy=0; ready=1; shift register, bit counter and repeat counter all 0.
  - rst overrides `load` in the same cycle.
  - rst mid-transmission aborts immediately: next cycle `dout`=IDLE_BIT and no `done` pulse.
- States, one-hot: IDLE, SHIFT, DONE.
- IDLE:
  - `dout`=IDLE_BIT.
  - On `load` at edge k: capture `data` into the hold register and the shift register, `rpt` into rep_cnt, and set bit_cnt=WIDTH-1.
  - Go to SHIFT; `dout` presents data[WIDTH-1] from edge k.
  - Without `load`, stay in IDLE.
- SHIFT:
  - Each edge drives the next bit, MSB-first. Bit i (i=1..WIDTH) is valid on `dout` between edges k+i-1 and k+i.
  - When bit_cnt=0 and rep_cnt>0: reload the shift register from the hold register, decrement rep_cnt, set bit_cnt=WIDTH-1. The first bit of the next copy follows immediately, with no idle bit between copies.
  - When bit_cnt=0 and rep_cnt=0: go to DONE, `dout`=IDLE_BIT, `done`=1.
- DONE:
  - Lasts exactly one cycle with `done`=1 and `ready`=0.
  - Returns to IDLE; `load` during DONE is ignored.
- Load rules:
  - `load` while not `ready` is ignored and not queued.
  - `data`/`rpt` changes after capture have no effect.
- Totals:
  - Total bits = WIDTH*(rpt+1).
  - `done` is high in the cycle beginning at edge k+WIDTH*(rpt+1).
  - The next load is accepted at edge k+WIDTH*(rpt+1)+1 or later.
- Widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - rep_cnt is REP_W bits and decrements only while nonzero, so it never wraps.
  - `rpt` = all-ones gives 2^REP_W copies.
- Unused one-hot encodings recover to IDLE with `dout`=IDLE_BIT.

Decomposition:
- Shared package holds:
  - one-hot state localparams TX_IDLE / TX_SHIFT / TX_DONE;
  - pattern constant PAT_0101 = 8'b01010101, shared by the detector bench and this block's bench.
- Optional sub-module `piso_shift` (WIDTH-bit parallel-load shift register with load/shift enables). All control logic stays in pattern_tx.

Test Plan:
- Reset hold: rst=1 for 3 cycles with load=1 and data=8'hFF -> dout=1, ready=1, busy=0, done=0 throughout; nothing is transmitted.
- Single word: load at edge k, data=8'h55, rpt=0 -> dout sequence 0,1,0,1,0,1,0,1 across cycles k..k+7. `done`=1 for cycle k+8 only. `ready`=1 again from k+9.
- Chained to the 01010101 detector, data=PAT_0101, rpt=1:
  - 16 bits are sent with no gap.
  - Detector flag pulses at edges k+9, k+11, k+13, k+15, k+17: five pulses.
  - `done` is at cycle k+16.
- Non-pattern word: data=8'hA5, rpt=2 -> 24 bits 10100101 repeated three times. `load` pulses while busy are ignored. `done` is at k+24.
- Reset mid-word: rst asserted while the 4th bit is on `dout` -> next cycle dout=1 and ready=1; `done` never asserts. A fresh load of 8'h0F then transmits 00001111 correctly.
- Boundary: rpt=4'hF, data=8'h01 -> 128 bits; `done` at k+128. `load` is accepted at k+129, with no counter wrap.
